// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner codes and a
// counter-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDbg = 1'b1
  } owner_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between CPU and debug requests, with an aging counter that forces the
// debug port through after MAX_WAIT consecutive lost cycles.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   cpu_req_i,
  input  logic   dbg_req_i,
  input  logic   idle_i,
  input  logic   dbg_active_i,
  output logic   grant_o,
  output owner_e winner_o
);

  localparam int unsigned WaitW = clog2(MAX_WAIT + 1);

  logic [WaitW-1:0] dbg_wait_q, dbg_wait_d;
  logic             dbg_aged;
  logic             dbg_win;

  always_comb begin
    dbg_aged   = (dbg_wait_q == WaitW'(MAX_WAIT));
    dbg_win    = dbg_req_i & (~cpu_req_i | dbg_aged);
    grant_o    = idle_i & (cpu_req_i | dbg_req_i);
    winner_o   = dbg_win ? OwnDbg : OwnCpu;
    dbg_wait_d = dbg_wait_q;
    // Aging runs whenever the debug port is waiting and is not the one being served.
    if (grant_o && dbg_win) begin
      dbg_wait_d = '0;
    end else if (dbg_req_i && !dbg_active_i && !dbg_aged) begin
      dbg_wait_d = dbg_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dbg_wait_q <= '0;
    end else begin
      dbg_wait_q <= dbg_wait_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory between the CPU control path and a
// debug/loader port: latch, issue one cycle, wait the read latency, ack with data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CntW = clog2(MEM_LAT);

  arb_state_e      state_q;
  owner_e          owner_q;
  logic            we_q;
  logic [CntW-1:0] cnt_q;

  logic   idle;
  logic   dbg_active;
  logic   grant;
  owner_e winner;

  assign idle       = (state_q == StIdle);
  assign dbg_active = ~idle & (owner_q == OwnDbg);
  assign busy       = ~idle;
  assign cpu_stall  = cpu_req & ~cpu_ack;

  mem_arb_select #(
    .MAX_WAIT(MAX_WAIT)
  ) u_select (
    .clk_i       (clk),
    .reset_i     (reset),
    .cpu_req_i   (cpu_req),
    .dbg_req_i   (dbg_req),
    .idle_i      (idle),
    .dbg_active_i(dbg_active),
    .grant_o     (grant),
    .winner_o    (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnCpu;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q <= winner;
            mem_en  <= 1'b1;
            if (winner == OwnDbg) begin
              we_q      <= dbg_we;
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end else begin
              we_q      <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            cpu_ack <= (owner_q == OwnCpu);
            dbg_ack <= (owner_q == OwnDbg);
            state_q <= StDone;
          end else begin
            cnt_q   <= CntW'(MEM_LAT - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          // Final wait cycle is the one in which mem_rdata is valid.
          if (cnt_q == '0) begin
            if (owner_q == OwnDbg) begin
              dbg_rdata <= mem_rdata;
              dbg_ack   <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, busy;
  logic [15:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic [7:0]  mem_addr;

  // Second instance with single-cycle memory latency.
  logic        c1_req = 1'b0, c1_we = 1'b0, d1_req = 1'b0, d1_we = 1'b0;
  logic [7:0]  c1_addr = '0, d1_addr = '0;
  logic [15:0] c1_wdata = '0, d1_wdata = '0, m1_rdata = '0;
  logic        c1_ack, c1_stall, d1_ack, m1_en, m1_we, busy1;
  logic [15:0] c1_rdata, d1_rdata, m1_wdata;
  logic [7:0]  m1_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(1), .MAX_WAIT(MAXW)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .dbg_ack(d1_ack), .dbg_rdata(d1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by its issue/ack cycle numbers.
  bit          t_act, t_dbg, t_we;
  int          t_issue, t_ack;
  logic [15:0] t_rd;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  int          wait_m;
  logic [15:0] e_cpu_rd, e_dbg_rd;
  bit          e_cpu_ack, e_dbg_ack;
  logic [15:0] shadow[256];
  bit          pend_cpu, pend_dbg;

  // Memory responder, fed only from the DUT's memory pins.
  logic [15:0] rmem[256];
  bit          r_valid;
  int          r_at;
  logic [7:0]  r_addr;

  task automatic model_reset();
    t_act = 0; wait_m = 0; e_cpu_rd = '0; e_dbg_rd = '0; m_addr = '0; m_wdata = '0;
    e_cpu_ack = 0; e_dbg_ack = 0; r_valid = 0;
  endtask

  task automatic model_latch();
    bit dbgw;
    if (!t_act) begin
      if (cpu_req || dbg_req) begin
        dbgw    = dbg_req && (!cpu_req || wait_m == MAXW);
        t_act   = 1;
        t_dbg   = dbgw;
        t_we    = dbgw ? dbg_we : cpu_we;
        m_addr  = dbgw ? dbg_addr : cpu_addr;
        m_wdata = dbgw ? dbg_wdata : cpu_wdata;
        t_issue = cyc + 1;
        t_ack   = t_we ? cyc + 2 : cyc + LAT + 2;
        if (t_we) shadow[m_addr] = m_wdata;
        else t_rd = shadow[m_addr];
        if (dbgw) begin
          wait_m = 0; pend_dbg = 0;
        end else begin
          pend_cpu = 0;
          if (dbg_req && wait_m < MAXW) wait_m++;
        end
      end
    end else if (dbg_req && !t_dbg && wait_m < MAXW) begin
      wait_m++;
    end
  endtask

  task automatic check_cycle();
    if (t_act && cyc > t_ack) t_act = 0;
    e_cpu_ack = t_act && cyc == t_ack && !t_dbg;
    e_dbg_ack = t_act && cyc == t_ack && t_dbg;
    if (e_cpu_ack && !t_we) e_cpu_rd = t_rd;
    if (e_dbg_ack && !t_we) e_dbg_rd = t_rd;
    chk("mem_en", mem_en, t_act && cyc == t_issue);
    chk("mem_we", mem_we, t_act && cyc == t_issue && t_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("busy", busy, t_act);
    chk("cpu_ack", cpu_ack, e_cpu_ack);
    chk("dbg_ack", dbg_ack, e_dbg_ack);
    chk("cpu_rdata", cpu_rdata, e_cpu_rd);
    chk("dbg_rdata", dbg_rdata, e_dbg_rd);
  endtask

  task automatic respond();
    if (mem_en) begin
      if (mem_we) rmem[mem_addr] = mem_wdata;
      else begin
        r_valid = 1; r_at = cyc + LAT; r_addr = mem_addr;
      end
    end
    if (r_valid && cyc == r_at) begin
      mem_rdata = rmem[r_addr];
      r_valid   = 0;
    end else begin
      mem_rdata = 16'($urandom);
    end
  endtask

  // Inputs for the current cycle are already driven; advance to the next negedge.
  task automatic step();
    #1;
    chk("cpu_stall", cpu_stall, cpu_req && !e_cpu_ack);
    model_latch();
    @(negedge clk);
    check_cycle();
    respond();
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    check_cycle();
    respond();
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    bit          preload;
    logic [15:0] memval;
    int          lat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int k;
    bit got;
    int order[$];
    int exp_order[4];

    tbl[0] = '{0, 0, 8'h10, 16'h0000, 1, 16'hBEEF, 4, 16'hBEEF};
    tbl[1] = '{1, 1, 8'h20, 16'h1234, 0, 16'h0000, 2, 16'h0000};
    tbl[2] = '{1, 0, 8'h20, 16'h0000, 0, 16'h0000, 4, 16'h1234};
    tbl[3] = '{0, 1, 8'h10, 16'h5555, 0, 16'h0000, 2, 16'hBEEF};
    tbl[4] = '{0, 0, 8'h10, 16'h0000, 0, 16'h0000, 4, 16'h5555};
    tbl[5] = '{0, 0, 8'hFF, 16'h0000, 1, 16'h0001, 4, 16'h0001};
    tbl[6] = '{1, 0, 8'h00, 16'h0000, 1, 16'hFFFF, 4, 16'hFFFF};
    exp_order = '{0, 0, 1, 0};

    for (int i = 0; i < 256; i++) begin
      shadow[i] = 16'($urandom);
      rmem[i]   = shadow[i];
    end
    pend_cpu = 0; pend_dbg = 0;
    #2;
    do_reset();

    // Directed single transactions.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].preload) begin
        shadow[tbl[i].addr] = tbl[i].memval;
        rmem[tbl[i].addr]   = tbl[i].memval;
      end
      if (tbl[i].dbg) begin
        dbg_req = 1; dbg_we = tbl[i].we; dbg_addr = tbl[i].addr; dbg_wdata = tbl[i].wdata;
      end else begin
        cpu_req = 1; cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      end
      k = 0; got = 0;
      while (!got && k < 20) begin
        step();
        k++;
        if (tbl[i].dbg ? dbg_ack : cpu_ack) begin
          got = 1; cpu_req = 0; dbg_req = 0;
        end
      end
      cpu_req = 0; dbg_req = 0;
      chk("vec_latency", k, tbl[i].lat);
      chk("vec_rdata", tbl[i].dbg ? dbg_rdata : cpu_rdata, tbl[i].exp_rd);
      step();
    end

    // Debug starvation bound with back-to-back CPU writes.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h0C0C;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h31;
    for (int i = 0; i < 16; i++) begin
      step();
      if (cpu_ack) order.push_back(0);
      if (dbg_ack) order.push_back(1);
    end
    cpu_req = 0; dbg_req = 0;
    chk("starve_ack_count_ok", order.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("starve_order", i < order.size() ? order[i] : -1,
                                    exp_order[i]);
    for (int i = 0; i < 8; i++) step();

    // Address change while waiting must not disturb the active read.
    shadow[8'h40] = 16'h4444; rmem[8'h40] = 16'h4444;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    step(); step();
    cpu_addr = 8'h41; cpu_we = 1; cpu_wdata = 16'h9999;
    step();
    chk("hold_addr", mem_addr, 8'h40);
    step();
    chk("hold_ack", cpu_ack, 1);
    chk("hold_rdata", cpu_rdata, 16'h4444);
    cpu_req = 0;
    step();

    // Reset in the middle of a read wait.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    step(); step();
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // Random traffic from both ports.
    pend_cpu = 0; pend_dbg = 0;
    for (int n = 0; n < 500; n++) begin
      if (t_act && !t_dbg) begin
        cpu_req = 1'($urandom); cpu_we = 1'($urandom);
        cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
      end else if (!pend_cpu) begin
        if ($urandom_range(0, 99) < 40) begin
          cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 8'($urandom_range(0, 15));
          cpu_wdata = 16'($urandom); pend_cpu = 1;
        end else cpu_req = 0;
      end
      if (t_act && t_dbg) begin
        dbg_req = 1'($urandom); dbg_we = 1'($urandom);
        dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
      end else if (!pend_dbg) begin
        if ($urandom_range(0, 99) < 40) begin
          dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 8'($urandom_range(0, 15));
          dbg_wdata = 16'($urandom); pend_dbg = 1;
        end else dbg_req = 0;
      end
      step();
    end
    cpu_req = 0; dbg_req = 0;
    for (int i = 0; i < 8; i++) step();

    // Single-cycle latency read on the second instance.
    c1_req = 1; c1_we = 0; c1_addr = 8'h33;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("lat1_mem_en", m1_en, j == 1);
      chk("lat1_mem_we", m1_we, 0);
      if (j == 1) chk("lat1_mem_addr", m1_addr, 8'h33);
      m1_rdata = (j == 2) ? 16'hA5A5 : 16'h0BAD;
      chk("lat1_cpu_ack", c1_ack, j == 3);
      chk("lat1_dbg_ack", d1_ack, 0);
      chk("lat1_busy", busy1, j <= 3);
      chk("lat1_stall", c1_stall, c1_req && j != 3);
      if (j == 3) begin
        chk("lat1_rdata", c1_rdata, 16'hA5A5);
        c1_req = 0;
      end
    end
    chk("lat1_wdata", m1_wdata, 16'h0000);
    chk("lat1_dbg_rdata", d1_rdata, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
